load_store_unit: RTL and testbench

Memory-access stage between the execute stage and `data_memory`. Accepts one load or store request at a time over a valid/ready handshake and sequences it into one or two byte accesses on the `data_memory` port (`address`, `write_data`, `memwrite`, `data_out`). Returns the read data, or a write acknowledge, to the writeback stage over a second valid/ready handshake. Supports single-byte and byte-pair (16-bit, little-endian) transfers.

---
 rtl/lsu_pkg.sv | 22 ++
 rtl/load_store_unit.sv | 99 +++++++++
 tb/tb_load_store_unit.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM state encoding, default widths
// and the latched request record.
package lsu_pkg;

  localparam int LSU_ADDR_W = 8;
  localparam int LSU_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTE0 = 2'd1,
    BYTE1 = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  typedef struct packed {
    logic                    write;
    logic                    pair;
    logic [LSU_ADDR_W-1:0]   addr;
    logic [2*LSU_DATA_W-1:0] wdata;
  } lsu_req_t;

endpackage

// File: rtl/load_store_unit.sv
// Memory-access stage: turns one load/store request into one or two byte
// accesses on the data_memory port and returns data/ack over a response handshake.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W,
  parameter int DATA_W = LSU_DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic                  req_pair,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [2*DATA_W-1:0]   resp_rdata,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W-1:0]     mem_write_data,
  output logic                  mem_memwrite,
  input  logic [DATA_W-1:0]     mem_data_out,
  output logic                  busy
);

  lsu_state_t             state_q, state_d;
  lsu_req_t               req_q, req_d;
  logic [2*DATA_W-1:0]    rdata_q, rdata_d;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d.write = req_write;
          req_d.pair  = req_pair;
          req_d.addr  = req_addr;
          req_d.wdata = req_wdata;
          // Cleared on accept so byte loads and stores respond with zero upper/all bits.
          rdata_d     = '0;
          state_d     = BYTE0;
        end
      end
      BYTE0: begin
        if (!req_q.write) rdata_d[DATA_W-1:0] = mem_data_out;
        state_d = req_q.pair ? BYTE1 : RESP;
      end
      BYTE1: begin
        if (!req_q.write) rdata_d[2*DATA_W-1:DATA_W] = mem_data_out;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
    end
  end

  // Memory port decode; the second byte address wraps within ADDR_W.
  always_comb begin
    mem_address    = '0;
    mem_write_data = '0;
    mem_memwrite   = 1'b0;
    case (state_q)
      BYTE0: begin
        mem_address    = req_q.addr;
        mem_write_data = req_q.wdata[DATA_W-1:0];
        mem_memwrite   = req_q.write & ~reset;
      end
      BYTE1: begin
        mem_address    = ADDR_W'(req_q.addr + 1'b1);
        mem_write_data = req_q.wdata[2*DATA_W-1:DATA_W];
        mem_memwrite   = req_q.write & ~reset;
      end
      default: ;
    endcase
  end

  assign req_ready  = (state_q == IDLE) && !reset;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array data memory beside the DUT plus an
// independent reference memory predicting every response.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_pair;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid, resp_ready;
  logic [15:0] resp_rdata;
  logic [7:0]  mem_address, mem_write_data, mem_data_out;
  logic        mem_memwrite, busy;
  logic        mem_init;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] wr_addr [4];
  logic [7:0] wr_data [4];
  int         wr_cyc [4];
  int         wr_cnt;
  int         last_acc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  load_store_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_pair(req_pair), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_memwrite(mem_memwrite), .mem_data_out(mem_data_out), .busy(busy)
  );

  function automatic logic [7:0] init_val(int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  // data_memory: combinational read, write committed at the end of the cycle
  assign mem_data_out = mem[mem_address];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (mem_memwrite) begin
      mem[mem_address] <= mem_write_data;
    end
  end

  function automatic logic [15:0] model_rd(logic w, logic p, logic [7:0] a);
    logic [7:0] a1;
    a1 = a + 8'd1;
    if (w) return 16'h0000;
    return p ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
  endfunction

  task automatic model_apply(logic w, logic p, logic [7:0] a, logic [15:0] wd);
    logic [7:0] a1;
    a1 = a + 8'd1;
    if (w) begin
      ref_mem[a] = wd[7:0];
      if (p) ref_mem[a1] = wd[15:8];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic w, input logic p, input logic [7:0] a,
                        input logic [15:0] wd, input int hold, input bit tie,
                        output logic [15:0] rd);
    int lat;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL req_ready_idle: got %b want 1", req_ready);
    end
    req_valid = 1'b1; req_write = w; req_pair = p; req_addr = a; req_wdata = wd;
    resp_ready = tie;
    step();
    last_acc = cyc;
    req_valid = 1'b0; req_write = 1'b0; req_pair = 1'b0; req_addr = '0; req_wdata = '0;
    wr_cnt = 0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 10) begin
      if (mem_memwrite === 1'b1 && wr_cnt < 4) begin
        wr_addr[wr_cnt] = mem_address;
        wr_data[wr_cnt] = mem_write_data;
        wr_cyc[wr_cnt]  = cyc;
        wr_cnt++;
      end
      step();
      lat++;
    end
    n_cmp++;
    if (lat != (p ? 3 : 2)) begin
      n_bad++; $display("FAIL resp_latency: got %0d want %0d", lat, p ? 3 : 2);
    end
    rd = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = 16'hDEAD;
      step();
      n_cmp++;
      if (resp_valid !== 1'b1 || resp_rdata !== rd || req_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL resp_hold: valid=%b rdata=%h ready=%b want 1/%h/0",
                 resp_valid, resp_rdata, req_ready, rd);
      end
    end
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b1;
    step();
    resp_ready = tie;
    n_cmp++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL resp_complete: valid=%b ready=%b busy=%b want 0/1/0",
               resp_valid, req_ready, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_pair = 1'b0; req_addr = '0;
    req_wdata = '0; resp_ready = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    step();
    mem_init = 1'b0;
    n_cmp++;
    if (req_ready !== 1'b0 || mem_memwrite !== 1'b0) begin
      n_bad++; $display("FAIL reset_active: ready=%b memwrite=%b want 0/0", req_ready, mem_memwrite);
    end
    step();
    reset = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0 ||
        resp_rdata !== 16'h0 || mem_address !== 8'h0 || mem_write_data !== 8'h0 ||
        mem_memwrite !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: ready=%b rv=%b busy=%b rd=%h ma=%h mwd=%h mw=%b want 1/0/0/0/0/0/0",
               req_ready, resp_valid, busy, resp_rdata, mem_address, mem_write_data, mem_memwrite);
    end
  endtask

  task automatic test_byte_store_load();
    logic [15:0] rd;
    do_req(1'b1, 1'b0, 8'h24, 16'h00E6, 0, 1'b0, rd);
    n_cmp++;
    if (wr_cnt != 1 || wr_addr[0] !== 8'h24 || wr_data[0] !== 8'hE6 || rd !== 16'h0) begin
      n_bad++;
      $display("FAIL byte_store: writes=%0d addr=%h data=%h rd=%h want 1/24/e6/0000",
               wr_cnt, wr_addr[0], wr_data[0], rd);
    end
    model_apply(1'b1, 1'b0, 8'h24, 16'h00E6);
    do_req(1'b0, 1'b0, 8'h24, 16'h0, 0, 1'b0, rd);
    n_cmp++;
    if (rd !== 16'h00E6 || wr_cnt != 0) begin
      n_bad++; $display("FAIL byte_load: got %h writes=%0d want 00e6/0", rd, wr_cnt);
    end
  endtask

  task automatic test_pair_wrap();
    logic [15:0] rd;
    do_req(1'b1, 1'b1, 8'hFF, 16'h0F55, 0, 1'b0, rd);
    n_cmp++;
    if (wr_cnt != 2 || wr_addr[0] !== 8'hFF || wr_data[0] !== 8'h55 ||
        wr_addr[1] !== 8'h00 || wr_data[1] !== 8'h0F || wr_cyc[1] - wr_cyc[0] != 1) begin
      n_bad++;
      $display("FAIL pair_store_wrap: n=%0d %h<=%h %h<=%h gap=%0d want 2 ff<=55 00<=0f gap 1",
               wr_cnt, wr_addr[0], wr_data[0], wr_addr[1], wr_data[1], wr_cyc[1] - wr_cyc[0]);
    end
    model_apply(1'b1, 1'b1, 8'hFF, 16'h0F55);
    do_req(1'b0, 1'b1, 8'hFF, 16'h0, 0, 1'b0, rd);
    n_cmp++;
    if (rd !== 16'h0F55) begin
      n_bad++; $display("FAIL pair_load_wrap: got %h want 0f55", rd);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] rd;
    do_req(1'b0, 1'b0, 8'h24, 16'h0, 5, 1'b0, rd);
    n_cmp++;
    if (rd !== 16'h00E6) begin
      n_bad++; $display("FAIL backpressure_data: got %h want 00e6", rd);
    end
    do_req(1'b0, 1'b0, 8'h24, 16'h0, 0, 1'b0, rd);
    n_cmp++;
    if (rd !== model_rd(1'b0, 1'b0, 8'h24)) begin
      n_bad++; $display("FAIL backpressure_ignored_store: got %h want %h", rd, model_rd(1'b0, 1'b0, 8'h24));
    end
  endtask

  task automatic test_reset_mid_pair();
    logic [15:0] rd;
    logic [15:0] exp;
    req_valid = 1'b1; req_write = 1'b1; req_pair = 1'b1; req_addr = 8'h35; req_wdata = 16'hAA55;
    step();
    req_valid = 1'b0;
    n_cmp++;
    if (mem_memwrite !== 1'b1 || mem_address !== 8'h35 || mem_write_data !== 8'h55) begin
      n_bad++; $display("FAIL reset_pair_byte0: mw=%b addr=%h data=%h want 1/35/55",
                        mem_memwrite, mem_address, mem_write_data);
    end
    step();
    reset = 1'b1;
    #1;
    n_cmp++;
    if (mem_memwrite !== 1'b0 || req_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_pair_gate: mw=%b ready=%b want 0/0", mem_memwrite, req_ready);
    end
    step();
    reset = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_pair_after: ready=%b rv=%b want 1/0", req_ready, resp_valid);
    end
    model_apply(1'b1, 1'b0, 8'h35, 16'hAA55);
    do_req(1'b0, 1'b0, 8'h35, 16'h0, 0, 1'b0, rd);
    n_cmp++;
    if (rd !== 16'h0055) begin
      n_bad++; $display("FAIL reset_pair_byte0_kept: got %h want 0055", rd);
    end
    exp = model_rd(1'b0, 1'b0, 8'h36);
    do_req(1'b0, 1'b0, 8'h36, 16'h0, 0, 1'b0, rd);
    n_cmp++;
    if (rd !== exp) begin
      n_bad++; $display("FAIL reset_pair_byte1_untouched: got %h want %h", rd, exp);
    end
    // reset landing in BYTE0 must suppress both bytes
    req_valid = 1'b1; req_write = 1'b1; req_pair = 1'b1; req_addr = 8'h50; req_wdata = 16'h1234;
    step();
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (mem_memwrite !== 1'b0) begin
      n_bad++; $display("FAIL reset_byte0_gate: mw=%b want 0", mem_memwrite);
    end
    step();
    reset = 1'b0;
    #1;
    exp = model_rd(1'b0, 1'b1, 8'h50);
    do_req(1'b0, 1'b1, 8'h50, 16'h0, 0, 1'b0, rd);
    n_cmp++;
    if (rd !== exp) begin
      n_bad++; $display("FAIL reset_byte0_nowrite: got %h want %h", rd, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd0, rd1;
    int acc0;
    resp_ready = 1'b1;
    do_req(1'b0, 1'b0, 8'h24, 16'h0, 0, 1'b1, rd0);
    acc0 = last_acc;
    do_req(1'b0, 1'b0, 8'h00, 16'h0, 0, 1'b1, rd1);
    n_cmp++;
    if (last_acc - acc0 != 3) begin
      n_bad++; $display("FAIL b2b_interval: got %0d want 3", last_acc - acc0);
    end
    n_cmp++;
    if (rd0 !== 16'h00E6 || rd1 !== 16'h000F) begin
      n_bad++; $display("FAIL b2b_data: got %h,%h want 00e6,000f", rd0, rd1);
    end
    resp_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] rd, exp, wd;
    logic [7:0]  a;
    logic        w, p;
    int          hold, want_wr;
    bit          tie;
    for (int n = 0; n < 40; n++) begin
      w    = 1'($urandom_range(0, 1));
      p    = 1'($urandom_range(0, 1));
      a    = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'(8'h40 + $urandom_range(0, 15));
      wd   = 16'($urandom);
      hold = $urandom_range(0, 2);
      tie  = (hold == 0) && ($urandom_range(0, 1) == 1);
      exp  = model_rd(w, p, a);
      do_req(w, p, a, wd, hold, tie, rd);
      want_wr = w ? (p ? 2 : 1) : 0;
      n_cmp++;
      if (rd !== exp || wr_cnt != want_wr) begin
        n_bad++;
        $display("FAIL random_txn%0d: w=%b p=%b a=%h rd=%h writes=%0d want %h/%0d",
                 n, w, p, a, rd, wr_cnt, exp, want_wr);
      end
      model_apply(w, p, a, wd);
      resp_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_byte_store_load();
    test_pair_wrap();
    test_backpressure();
    test_reset_mid_pair();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
